pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Parametrised hazard/forwarding controller for the IF-ID-EX-WB core. Tracks up to DEPTH in-flight
//  writers past ID in a scoreboard and detects RAW hazards on two ID source operands. For each hazard
//  it either forwards the producing stage's result or stalls IF/ID. On a taken branch it squashes
//  younger instructions for BR_FLUSH cycles. Replaces the single stall wire between ID and EX.
// PARAMETERS
//  REG_AW    4   register address width
//  DATA_W    32  datapath width
//  DEPTH     2   tracked stages after ID (entry 0 = EX, entry DEPTH-1 = WB); legal 1..4
//  LD_LAT    1   extra cycles before a load result is forwardable; legal 0..3
//  BR_FLUSH  2   cycles flush_o stays high after a taken branch; legal 1..3
//  CNT_W     16  stall counter width
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               asynchronous reset, active-high
//  id_valid_i     in   1               ID holds a valid instruction
//  id_wb_en_i     in   1               ID instruction writes a register
//  id_is_ld_i     in   1               ID instruction is a load
//  id_rd_addr_i   in   REG_AW          ID destination register
//  id_rs_addr_i   in   REG_AW          source A address
//  id_rt_addr_i   in   REG_AW          source B address
//  id_rs_use_i    in   1               source A is read
//  id_rt_use_i    in   1               source B is read
//  ex_stall_i     in   1               EX is busy (multi-cycle op)
//  branch_en_i    in   1               taken branch resolved in EX this cycle
//  stage_data_i   in   DEPTH*DATA_W    result of entry k at bits [k*DATA_W +: DATA_W]
//  issue_o        out  1               ID instruction advances into EX this cycle
//  stall_o        out  1               hold IF and ID
//  flush_o        out  1               squash IF/ID contents
//  fwd_rs_en_o    out  1               forward source A
//  fwd_rs_data_o  out  DATA_W          forwarded value for source A
//  fwd_rt_en_o    out  1               forward source B
//  fwd_rt_data_o  out  DATA_W          forwarded value for source B
//  stall_cnt_o    out  CNT_W           saturating count of cycles with stall_o=1
// BEHAVIOUR
//  - Reset: all entries invalid, flush_cnt=0, stall_cnt_o=0. All combinational outputs evaluate to 0.
//  - Entry fields: {vld, wb_en, rd[REG_AW], rdy_cnt[2]}.
//  - Advance when !ex_stall_i: entry0 <= issued ID instruction, or a bubble if none. Entry k <= entry k-1.
//    Entry DEPTH-1 retires; the register file sees its write in the same cycle.
//  - On advance, a new entry loads rdy_cnt = id_is_ld_i ? LD_LAT : 0.
//  - rdy_cnt decrements every cycle while >0, including during ex_stall_i.
//  - An entry is ready when rdy_cnt == 0.
//  - Match per used source: vld & wb_en & (rd == src). The youngest (lowest k) match wins.
//      Youngest match ready     -> fwd_*_en_o=1, data = stage_data_i entry k, combinational, 0-cycle latency.
//      Youngest match not ready -> hazard.
//      No match                 -> fwd_*_en_o=0, data=0.
//  - stall_o = ex_stall_i | (id_valid_i & hazard_A|hazard_B), forced to 0 while flush_o=1.
//  - issue_o = id_valid_i & !stall_o & !flush_o & !branch_en_i.
//  - Branch: branch_en_i sets flush_cnt=BR_FLUSH next cycle. flush_o = branch_en_i | (flush_cnt != 0).
//    flush_cnt decrements to 0.
//  - Branch in the same cycle as ex_stall_i: ignored. EX must hold branch_en_i until it is not stalled.
//  - Branch while flush_cnt != 0: reloads flush_cnt to BR_FLUSH.
//  - The branch entry itself (entry 0) is never invalidated. Older entries complete normally.
//  - stall_cnt_o increments when stall_o=1 and saturates at all-ones.
//  - Reset asserted mid-operation clears every entry and the counters immediately. No partial state survives.
// STRUCTURE
//  - pipe_defs.vh (shared include): REG_AW default, entry field offsets, rdy_cnt width.
//    Also consumed by ID and EX.
//  - One sub-module, hz_src_check, instantiated twice (source A, source B).
//    It does the priority match and forward mux over the entry vector and outputs {hazard, fwd_en, fwd_data}.
//  - The top holds the scoreboard shift register, flush counter, stall counter and the combine logic.
// TESTING
//  1. Reset with all inputs 0 -> stall_o=0, flush_o=0, issue_o=0, fwd_*_en_o=0, stall_cnt_o=0.
//  2. ALU r3 issued; next cycle ID reads r3 with stage_data_i[0]=32'h0000_00A5
//     -> fwd_rs_en_o=1, fwd_rs_data_o=32'hA5, stall_o=0.
//  3. Load r5 (LD_LAT=1); next ID reads r5 -> stall_o=1 for 1 cycle, then fwd from entry1.
//     stall_cnt_o=1.
//  4. r2 written in entry0 and entry1 with different data -> forward entry0 value (youngest wins).
//  5. branch_en_i pulse, BR_FLUSH=2 -> flush_o high 3 cycles total (pulse + 2); issue_o=0 throughout.
//     A concurrent hazard does not raise stall_o.
//  6. ex_stall_i held 4 cycles with pending load -> scoreboard frozen, stall_o=1, rdy_cnt reaches 0.
//     Release -> forward with no extra stall. Assert rst mid-sequence -> all outputs 0 next sample.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_pkg
//   Shared definitions for the hazard/forwarding controller: the width of the
//   per-entry ready countdown, its type, the default register address width,
//   and the countdown helper that the scoreboard applies to every entry.
//   No ports (package).
// ---------------------------------------------------------------------------
package pipe_hazard_unit_pkg;

   localparam int REG_AW_DEF = 4;
   localparam int RDY_W      = 2;   // holds LD_LAT up to 3

   typedef logic [RDY_W-1:0] rdy_t;

   // Ready countdown: moves toward zero and stays there.
   function automatic rdy_t rdy_dec(input rdy_t c);
      return (c != '0) ? c - rdy_t'(1) : c;
   endfunction

endpackage

// File: rtl/pipe_hazard_unit_hz_src_check.sv
// ---------------------------------------------------------------------------
// hz_src_check
//   Priority match of one ID source operand against the scoreboard entries.
//   The youngest (lowest index) matching writer decides the outcome: forward
//   its stage result if it is ready, otherwise flag a hazard.
// Ports
//   src_use     in   source is read by the ID instruction
//   src_addr    in   source register address
//   ent_vld     in   per-entry valid
//   ent_wb_en   in   per-entry register write enable
//   ent_rdy     in   per-entry result forwardable
//   ent_rd      in   per-entry destination, entry k at [k*REG_AW +: REG_AW]
//   stage_data  in   per-entry result, entry k at [k*DATA_W +: DATA_W]
//   hazard      out  youngest match is not ready yet
//   fwd_en      out  youngest match is ready, forward it
//   fwd_data    out  forwarded value (0 when not forwarding)
// ---------------------------------------------------------------------------
module hz_src_check
   import pipe_hazard_unit_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input  logic                    src_use,
   input  logic [REG_AW-1:0]       src_addr,
   input  logic [DEPTH-1:0]        ent_vld,
   input  logic [DEPTH-1:0]        ent_wb_en,
   input  logic [DEPTH-1:0]        ent_rdy,
   input  logic [DEPTH*REG_AW-1:0] ent_rd,
   input  logic [DEPTH*DATA_W-1:0] stage_data,
   output logic                    hazard,
   output logic                    fwd_en,
   output logic [DATA_W-1:0]       fwd_data
);

   // Walk oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      hazard   = 1'b0;
      fwd_en   = 1'b0;
      fwd_data = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (src_use && ent_vld[k] && ent_wb_en[k] &&
             (ent_rd[k*REG_AW +: REG_AW] == src_addr)) begin
            hazard   = ~ent_rdy[k];
            fwd_en   = ent_rdy[k];
            fwd_data = ent_rdy[k] ? stage_data[k*DATA_W +: DATA_W] : '0;
         end
      end
   end

endmodule

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//   Hazard/forwarding controller for the IF-ID-EX-WB core. Keeps a
//   scoreboard of in-flight writers past ID (entry 0 = EX .. DEPTH-1 = WB),
//   resolves RAW hazards on both ID sources by forwarding or stalling, and
//   squashes IF/ID for BR_FLUSH cycles after a taken branch.
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   id_valid_i .. id_rt_use_i  decoded ID instruction
//   ex_stall_i               EX busy; scoreboard holds position
//   branch_en_i              taken branch resolved in EX
//   stage_data_i             result of entry k at [k*DATA_W +: DATA_W]
//   issue_o                  ID instruction moves into EX this cycle
//   stall_o, flush_o         IF/ID hold / squash
//   fwd_rs_*_o, fwd_rt_*_o   forwarding for source A / source B
//   stall_cnt_o              saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_hazard_unit
   import pipe_hazard_unit_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 2,
   parameter int LD_LAT   = 1,
   parameter int BR_FLUSH = 2,
   parameter int CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    id_valid_i,
   input  logic                    id_wb_en_i,
   input  logic                    id_is_ld_i,
   input  logic [REG_AW-1:0]       id_rd_addr_i,
   input  logic [REG_AW-1:0]       id_rs_addr_i,
   input  logic [REG_AW-1:0]       id_rt_addr_i,
   input  logic                    id_rs_use_i,
   input  logic                    id_rt_use_i,
   input  logic                    ex_stall_i,
   input  logic                    branch_en_i,
   input  logic [DEPTH*DATA_W-1:0] stage_data_i,
   output logic                    issue_o,
   output logic                    stall_o,
   output logic                    flush_o,
   output logic                    fwd_rs_en_o,
   output logic [DATA_W-1:0]       fwd_rs_data_o,
   output logic                    fwd_rt_en_o,
   output logic [DATA_W-1:0]       fwd_rt_data_o,
   output logic [CNT_W-1:0]        stall_cnt_o
);

   localparam rdy_t       LD_RDY = rdy_t'(LD_LAT);
   localparam logic [1:0] BR_CNT = 2'(BR_FLUSH);

   logic [DEPTH-1:0]        sb_vld;
   logic [DEPTH-1:0]        sb_wb_en;
   logic [DEPTH*REG_AW-1:0] sb_rd;
   rdy_t                    sb_rdy [DEPTH];
   logic [DEPTH-1:0]        sb_ready;
   logic [1:0]              flush_cnt;
   logic                    branch_take;
   logic                    haz_rs;
   logic                    haz_rt;

   always_comb begin
      for (int k = 0; k < DEPTH; k++) sb_ready[k] = (sb_rdy[k] == '0);
   end

   hz_src_check #(.REG_AW(REG_AW), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_chk_rs (
      .src_use(id_rs_use_i), .src_addr(id_rs_addr_i),
      .ent_vld(sb_vld), .ent_wb_en(sb_wb_en), .ent_rdy(sb_ready), .ent_rd(sb_rd),
      .stage_data(stage_data_i),
      .hazard(haz_rs), .fwd_en(fwd_rs_en_o), .fwd_data(fwd_rs_data_o)
   );

   hz_src_check #(.REG_AW(REG_AW), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_chk_rt (
      .src_use(id_rt_use_i), .src_addr(id_rt_addr_i),
      .ent_vld(sb_vld), .ent_wb_en(sb_wb_en), .ent_rdy(sb_ready), .ent_rd(sb_rd),
      .stage_data(stage_data_i),
      .hazard(haz_rt), .fwd_en(fwd_rt_en_o), .fwd_data(fwd_rt_data_o)
   );

   // A branch that arrives while EX is stalled is not yet resolved; EX holds it.
   assign branch_take = branch_en_i & ~ex_stall_i;
   assign flush_o     = branch_take | (flush_cnt != 2'd0);
   assign stall_o     = (ex_stall_i | (id_valid_i & (haz_rs | haz_rt))) & ~flush_o;
   assign issue_o     = id_valid_i & ~stall_o & ~flush_o & ~branch_en_i;

   // ID -> EX boundary: scoreboard shift; ready countdown runs even when held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sb_vld   <= '0;
         sb_wb_en <= '0;
         sb_rd    <= '0;
         for (int k = 0; k < DEPTH; k++) sb_rdy[k] <= '0;
      end else if (!ex_stall_i) begin
         sb_vld[0]          <= issue_o;
         sb_wb_en[0]        <= issue_o & id_wb_en_i;
         sb_rd[0 +: REG_AW] <= id_rd_addr_i;
         sb_rdy[0]          <= (issue_o && id_is_ld_i) ? LD_RDY : '0;
         for (int k = 1; k < DEPTH; k++) begin
            sb_vld[k]                <= sb_vld[k-1];
            sb_wb_en[k]              <= sb_wb_en[k-1];
            sb_rd[k*REG_AW +: REG_AW] <= sb_rd[(k-1)*REG_AW +: REG_AW];
            sb_rdy[k]                <= rdy_dec(sb_rdy[k-1]);
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) sb_rdy[k] <= rdy_dec(sb_rdy[k]);
      end
   end

   // Flush window and stall statistics.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flush_cnt   <= 2'd0;
         stall_cnt_o <= '0;
      end else begin
         if (branch_take)             flush_cnt <= BR_CNT;
         else if (flush_cnt != 2'd0)  flush_cnt <= flush_cnt - 2'd1;
         if (stall_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit
//   Directed bench for pipe_hazard_unit with default parameters
//   (DEPTH=2, LD_LAT=1, BR_FLUSH=2). Inputs change 1 time unit after the
//   rising edge; outputs are sampled 1 unit later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_unit;

   localparam int REG_AW = 4;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;
   localparam int CNT_W  = 16;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    id_valid, id_wb_en, id_is_ld;
   logic [REG_AW-1:0]       id_rd, id_rs, id_rt;
   logic                    id_rs_use, id_rt_use;
   logic                    ex_stall, branch_en;
   logic [DEPTH*DATA_W-1:0] stage_data;
   logic                    issue, stall, flush;
   logic                    fwd_rs_en, fwd_rt_en;
   logic [DATA_W-1:0]       fwd_rs_data, fwd_rt_data;
   logic [CNT_W-1:0]        stall_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_hazard_unit #(
      .REG_AW(REG_AW), .DATA_W(DATA_W), .DEPTH(DEPTH),
      .LD_LAT(1), .BR_FLUSH(2), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .id_valid_i(id_valid), .id_wb_en_i(id_wb_en), .id_is_ld_i(id_is_ld),
      .id_rd_addr_i(id_rd), .id_rs_addr_i(id_rs), .id_rt_addr_i(id_rt),
      .id_rs_use_i(id_rs_use), .id_rt_use_i(id_rt_use),
      .ex_stall_i(ex_stall), .branch_en_i(branch_en), .stage_data_i(stage_data),
      .issue_o(issue), .stall_o(stall), .flush_o(flush),
      .fwd_rs_en_o(fwd_rs_en), .fwd_rs_data_o(fwd_rs_data),
      .fwd_rt_en_o(fwd_rt_en), .fwd_rt_data_o(fwd_rt_data),
      .stall_cnt_o(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic wb, input logic ld, input logic [3:0] rd,
                         input logic [3:0] rs, input logic rsu, input logic [3:0] rt, input logic rtu);
      id_valid = v;  id_wb_en = wb; id_is_ld = ld; id_rd = rd;
      id_rs = rs;    id_rs_use = rsu; id_rt = rt;  id_rt_use = rtu;
   endtask

   initial begin
      rst = 1'b1; ex_stall = 1'b0; branch_en = 1'b0; stage_data = '0;
      set_id(0, 0, 0, 4'd0, 4'd0, 0, 4'd0, 0);
      tick(); tick();
      #1;
      // 1. reset state
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_issue", 32'(issue), 32'd0);
      chk("rst_fwd_rs_en", 32'(fwd_rs_en), 32'd0);
      chk("rst_fwd_rt_en", 32'(fwd_rt_en), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // 2. ALU writes r3, consumer forwards from EX
      set_id(1, 1, 0, 4'd3, 4'd0, 0, 4'd0, 0);
      #1 chk("alu_issue", 32'(issue), 32'd1);
      tick();
      set_id(1, 0, 0, 4'd0, 4'd3, 1, 4'd0, 0);
      stage_data = {32'h0, 32'h0000_00A5};
      #1;
      chk("alu_fwd_en", 32'(fwd_rs_en), 32'd1);
      chk("alu_fwd_data", fwd_rs_data, 32'h0000_00A5);
      chk("alu_no_stall", 32'(stall), 32'd0);
      tick();

      // 3. load r5 then consumer: one stall cycle, then forward from WB
      set_id(1, 1, 1, 4'd5, 4'd0, 0, 4'd0, 0);
      tick();
      set_id(1, 0, 0, 4'd0, 4'd5, 1, 4'd0, 0);
      stage_data = {32'h0000_0022, 32'h0000_0011};
      #1;
      chk("ld_stall", 32'(stall), 32'd1);
      chk("ld_stall_issue", 32'(issue), 32'd0);
      chk("ld_stall_fwd_en", 32'(fwd_rs_en), 32'd0);
      tick();
      chk("ld_fwd_stall", 32'(stall), 32'd0);
      chk("ld_fwd_en", 32'(fwd_rs_en), 32'd1);
      chk("ld_fwd_data", fwd_rs_data, 32'h0000_0022);
      chk("ld_stall_cnt", 32'(stall_cnt), 32'd1);
      tick();

      // 4. r2 in both entries: youngest wins; unmatched source stays off
      set_id(1, 1, 0, 4'd2, 4'd0, 0, 4'd0, 0);
      tick();
      tick();
      set_id(1, 0, 0, 4'd0, 4'd7, 1, 4'd2, 1);
      stage_data = {32'h0000_BBBB, 32'h0000_AAAA};
      #1;
      chk("young_fwd_rt_en", 32'(fwd_rt_en), 32'd1);
      chk("young_fwd_rt_data", fwd_rt_data, 32'h0000_AAAA);
      chk("nomatch_rs_en", 32'(fwd_rs_en), 32'd0);
      chk("nomatch_rs_data", fwd_rs_data, 32'd0);
      tick();

      // 5. branch with a concurrent load-use hazard
      set_id(1, 1, 1, 4'd6, 4'd0, 0, 4'd0, 0);
      tick();
      set_id(1, 0, 0, 4'd0, 4'd6, 1, 4'd0, 0);
      branch_en = 1'b1;
      #1;
      chk("br_flush_0", 32'(flush), 32'd1);
      chk("br_stall_masked", 32'(stall), 32'd0);
      chk("br_issue_0", 32'(issue), 32'd0);
      tick();
      branch_en = 1'b0;
      #1;
      chk("br_flush_1", 32'(flush), 32'd1);
      chk("br_issue_1", 32'(issue), 32'd0);
      tick();
      chk("br_flush_2", 32'(flush), 32'd1);
      chk("br_issue_2", 32'(issue), 32'd0);
      tick();
      chk("br_flush_end", 32'(flush), 32'd0);
      chk("br_issue_end", 32'(issue), 32'd1);
      chk("br_stall_cnt", 32'(stall_cnt), 32'd1);
      tick();

      // 6. EX stall for 4 cycles with a pending load; branch during stall ignored
      set_id(1, 1, 1, 4'd9, 4'd0, 0, 4'd0, 0);
      tick();
      set_id(1, 0, 0, 4'd0, 4'd9, 1, 4'd0, 0);
      stage_data = {32'h0000_0000, 32'hCAFE_0009};
      ex_stall = 1'b1;
      branch_en = 1'b1;
      #1;
      chk("exs_stall", 32'(stall), 32'd1);
      chk("exs_br_ignored", 32'(flush), 32'd0);
      chk("exs_issue", 32'(issue), 32'd0);
      chk("exs_not_ready", 32'(fwd_rs_en), 32'd0);
      tick();
      branch_en = 1'b0;
      #1;
      chk("exs_frozen_ready", 32'(fwd_rs_en), 32'd1);
      chk("exs_stall_2", 32'(stall), 32'd1);
      chk("exs_no_flush", 32'(flush), 32'd0);
      tick();
      tick();
      tick();
      ex_stall = 1'b0;
      #1;
      chk("exs_rel_stall", 32'(stall), 32'd0);
      chk("exs_rel_fwd_en", 32'(fwd_rs_en), 32'd1);
      chk("exs_rel_fwd_data", fwd_rs_data, 32'hCAFE_0009);
      chk("exs_rel_issue", 32'(issue), 32'd1);
      chk("exs_stall_cnt", 32'(stall_cnt), 32'd5);

      // Mid-operation reset: entries and counters clear immediately
      #2;
      rst = 1'b1;
      id_valid = 1'b0;
      #1;
      chk("mid_rst_fwd_rs_en", 32'(fwd_rs_en), 32'd0);
      chk("mid_rst_fwd_rs_data", fwd_rs_data, 32'd0);
      chk("mid_rst_stall", 32'(stall), 32'd0);
      chk("mid_rst_flush", 32'(flush), 32'd0);
      chk("mid_rst_issue", 32'(issue), 32'd0);
      chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
